// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioning logic.
// Consumers: button_debouncer (optional long-press feature guarded by BUTTON_LONG_PRESS_EN).
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 50_000_000;

    // Pin level that corresponds to a pressed button for the given polarity.
    function automatic logic pressed_level(input logic active_low);
        return ~active_low;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value
// so the synchronised signal starts at a known inactive level.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button into a clean level plus press/release strobes.
// Define BUTTON_LONG_PRESS_EN to add the hold counter and the long_press strobe.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_out,
    output logic press_pulse,
    output logic release_pulse
`ifdef BUTTON_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           IDLE_LVL  = ACTIVE_LOW;
    localparam logic           PRESS_LVL = pressed_level(ACTIVE_LOW);

    logic          btn_sync;
    logic          act;
    btn_state_t    state;
    logic [CW-1:0] cnt;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // act is 1 while the synchronised pin shows a press, independent of polarity.
    assign act = btn_sync ^ ACTIVE_LOW;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int            HW        = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0] hold;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RELEASED;
            cnt           <= '0;
            btn_out       <= IDLE_LVL;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
            hold          <= '0;
            long_press    <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
            long_press    <= 1'b0;
`endif
            case (state)
                RELEASED: begin
                    if (act) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    // A reversal on the terminal-count cycle still rejects the press.
                    if (!act) begin
                        state <= RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        btn_out     <= PRESS_LVL;
                        press_pulse <= 1'b1;
`ifdef BUTTON_LONG_PRESS_EN
                        hold        <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!act) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (act) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state         <= RELEASED;
                        btn_out       <= IDLE_LVL;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                end
            endcase
`ifdef BUTTON_LONG_PRESS_EN
            // Hold time keeps running through release qualification; it saturates
            // so long_press fires at most once per accepted press.
            if (state == PRESSED || state == RELEASE_CHK) begin
                if (hold != HOLD_SAT) begin
                    hold <= hold + 1'b1;
                end
                if (hold == HOLD_LAST) begin
                    long_press <= 1'b1;
                end
            end
`endif
        end
    end

    assert property (@(posedge clk) (DEBOUNCE_CYCLES >= 2) && (LONG_PRESS_CYCLES > DEBOUNCE_CYCLES));

    assert property (@(posedge clk) disable iff (reset) !(press_pulse && release_pulse));

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions one raw mechanical push-button input for the HPS button PIO. It synchronises the asynchronous pin, rejects contact bounce with a counter-qualified state machine, and drives a clean level into the PIO `in_port`. That PIO's edge-capture logic then sees exactly one transition per physical press or release. The block also emits single-cycle press and release strobes, plus an optional long-press strobe, for fabric-side consumers.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stable-input cycles required before accepting a change (20 ms at 50 MHz); legal range 2..2^24.
- `LONG_PRESS_CYCLES`, default 50_000_000: press duration that raises `long_press`; must be greater than `DEBOUNCE_CYCLES`; used only with the macro below.
- `ACTIVE_LOW`, default 1: 1 means the raw pin reads 0 when pressed.
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high reset.
- `btn_in` input 1: raw, asynchronous button pin.
- `btn_out` output 1: debounced level with the same polarity as `btn_in`; connects to the PIO `in_port`.
- `press_pulse` output 1: one-cycle strobe on an accepted press.
- `release_pulse` output 1: one-cycle strobe on an accepted release.
- `long_press` output 1: one-cycle strobe; present only with `BUTTON_LONG_PRESS_EN`.

## Operation
- Synchroniser:
  - Two flops on `btn_in`, reset to the inactive level (`ACTIVE_LOW`).
  - `act` = synchronised value XOR `ACTIVE_LOW` (1 = pressed).
- FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Reset state is RELEASED.
- RELEASED:
  - If `act` = 1: go to PRESS_CHK and clear `cnt`.
- PRESS_CHK:
  - If `act` = 0: return to RELEASED (bounce rejected, no outputs change).
  - Else if `cnt` = `DEBOUNCE_CYCLES`-1: go to PRESSED, drive `btn_out` to the active level, assert `press_pulse` for one cycle, clear `hold`.
  - Else: `cnt`++.
- PRESSED:
  - If `act` = 0: go to RELEASE_CHK and clear `cnt`.
- RELEASE_CHK:
  - If `act` = 1: return to PRESSED (`btn_out` unchanged, `hold` not cleared).
  - Else if `cnt` = `DEBOUNCE_CYCLES`-1: go to RELEASED, drive `btn_out` inactive, assert `release_pulse`.
  - Else: `cnt`++.
- Counter width:
  - `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits.
  - `hold` is `$clog2(LONG_PRESS_CYCLES+1)` bits and saturates; it never wraps.
- All outputs are registered.
- Reset values:
  - `btn_out` = `ACTIVE_LOW` (released level).
  - `press_pulse`, `release_pulse`, `long_press` = 0.
- Reset mid-operation:
  - Reset aborts any state immediately, with no pulse emitted.
  - A button still held when reset deasserts is reported as a fresh press after the full latency.

## Timing
- Latency from a stable raw edge to the `btn_out` change is `DEBOUNCE_CYCLES`+3 clock edges:
  - 2 edges for the synchroniser.
  - 1 edge to enter the CHK state.
  - `DEBOUNCE_CYCLES` edges to qualify.
- `press_pulse` and `release_pulse` are high in the same cycle that `btn_out` first shows its new value.
- Any single-cycle reversal of `act` during a CHK state restarts qualification from scratch.
- At most one `btn_out` transition occurs per `DEBOUNCE_CYCLES`+1 cycles.
- Simultaneous events: a reversal of `act` on the exact terminal-count cycle wins, so the transition is rejected.

## Configuration
- `BUTTON_LONG_PRESS_EN` defined:
  - `hold` counts every cycle in PRESSED and RELEASE_CHK.
  - When `hold` reaches `LONG_PRESS_CYCLES`-1, `long_press` pulses once per press.
  - `hold` then saturates, so no repeat pulse occurs.
- `BUTTON_LONG_PRESS_EN` undefined:
  - The `hold` counter and the `long_press` port do not exist.
  - All other behaviour is identical.

## Structure
- Shared package `button_pkg` holds:
  - The state enum `btn_state_t` (RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK).
  - The localparam for the default debounce count.
- One sub-module, `sync_2ff`: the reusable two-flop synchroniser, with a reset-value parameter and synchronous active-high reset.
- The FSM and counters live in `button_debouncer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=10, `ACTIVE_LOW`=1.
- Clean press: `btn_in` 1→0 and held → `btn_out` falls 7 cycles later, `press_pulse` = 1 in exactly that cycle.
- Bounce: `btn_in` toggles 0,1,0,1 every 2 cycles, then holds 0 → no pulse during toggling; one `press_pulse` 7 cycles after the final edge.
- Release glitch: while pressed, `btn_in` goes high for 2 cycles and then low → `btn_out` stays 0, no `release_pulse`.
- Clean release: `btn_in` 0→1 and held → `btn_out` rises 7 cycles later with a single `release_pulse`.
- Long press (macro defined): hold pressed for 30 cycles → exactly one `long_press`, 10 cycles after `press_pulse`.
- Reset mid-press: assert `reset` in PRESS_CHK while `btn_in` = 0, deassert after 1 cycle → `btn_out` = 1 during reset, no pulses; `press_pulse` appears 7 cycles after deassertion.
